// File: rtl/request_encoder_pkg.sv
//------------------------------------------------------------------------------
// request_encoder_pkg
// Shared types, sizes and helpers for the 32-line request encoder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package request_encoder_pkg;

  localparam int NUM_LINES   = 32;
  localparam int IDX_W       = 5;
  localparam int GROUP_W     = 8;
  localparam int GROUP_IDX_W = 3;
  localparam int CNT_W       = 6;

  typedef logic [NUM_LINES-1:0] line_vec_t;
  typedef logic [IDX_W-1:0]     line_idx_t;

  // Number of set bits in a line vector (0..32).
  function automatic logic [CNT_W-1:0] popcount(input line_vec_t v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // One-hot line mask for an encoded index.
  function automatic line_vec_t onehot(input line_idx_t i);
    line_vec_t one;
    one = line_vec_t'(1);
    return one << i;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_encoder8x3.sv
//------------------------------------------------------------------------------
// prio_encoder8x3
// Combinational 8-to-3 priority encoder; bit 0 has the highest priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prio_encoder8x3 (
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    out = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (in[i]) out = 3'(i);
    end
  end

  assign any = |in;

endmodule

`default_nettype wire

// File: rtl/request_encoder32.sv
//------------------------------------------------------------------------------
// request_encoder32
// Sticky 32-line request capture with a valid/ready priority-encoded grant.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module request_encoder32
  import request_encoder_pkg::*;
#(
  parameter int GROUP_W  = 8,
  parameter int N_GROUPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  line_vec_t         req,
  input  logic              enable,
  output line_idx_t         idx,
  output logic              idx_valid,
  input  logic              idx_ready,
  output line_vec_t         pending,
  output logic [CNT_W-1:0]  pending_cnt
);

  localparam int GSEL_W = IDX_W - GROUP_IDX_W;

  logic                   handshake;
  line_vec_t              shown_mask;
  line_vec_t              clear_mask;
  line_vec_t              pending_next;
  line_vec_t              selectable;
  logic [N_GROUPS-1:0]    leaf_any;
  logic [GROUP_IDX_W-1:0] leaf_out [N_GROUPS];
  logic [GSEL_W-1:0]      grp_sel;
  line_idx_t              sel_idx;
  logic                   sel_any;
  logic                   can_advance;

  assign handshake    = idx_valid && idx_ready;
  // The line on idx is excluded from selection so a back-to-back issue never
  // repeats the grant being accepted.
  assign shown_mask   = idx_valid ? onehot(idx) : '0;
  assign clear_mask   = handshake ? onehot(idx) : '0;
  // New requests are ORed in last so a set on the accepted line wins.
  assign pending_next = (pending & ~clear_mask) | req;
  assign selectable   = pending & ~shown_mask;

  generate
    for (genvar g = 0; g < N_GROUPS; g++) begin : g_leaf
      prio_encoder8x3 u_leaf (
        .in  (selectable[g*GROUP_W +: GROUP_W]),
        .out (leaf_out[g]),
        .any (leaf_any[g])
      );
    end
  endgenerate

  // Lowest-numbered group with a selectable line supplies the upper index bits.
  always_comb begin
    grp_sel = '0;
    for (int g = N_GROUPS - 1; g >= 0; g--) begin
      if (leaf_any[g]) grp_sel = GSEL_W'(g);
    end
  end

  assign sel_idx     = {grp_sel, leaf_out[grp_sel]};
  assign sel_any     = |leaf_any;
  assign can_advance = !idx_valid || handshake;

  // Pending capture, population count and grant issue/hold/drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_cnt <= '0;
      idx         <= '0;
      idx_valid   <= 1'b0;
    end else begin
      pending     <= pending_next;
      pending_cnt <= popcount(pending_next);
      if (can_advance) begin
        if (enable && sel_any) begin
          idx       <= sel_idx;
          idx_valid <= 1'b1;
        end else begin
          idx_valid <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
